// File: rtl/screen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : screen_pkg
// Purpose  : Shared screen-peripheral constants and frame sequencer states.
// Revision : 1.0  initial release
// ============================================================================
package screen_pkg;

    localparam int c_WORD_W          = 32;
    localparam int c_WORDS_PER_FRAME = 96;    // 32x32 RGB, one bit per colour

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t c_ST_IDLE   = 3'd0;
    localparam seq_state_t c_ST_INIT   = 3'd1;
    localparam seq_state_t c_ST_STREAM = 3'd2;
    localparam seq_state_t c_ST_CLEAR  = 3'd3;
    localparam seq_state_t c_ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/screen_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : screen_word_fifo
// Purpose  : Show-ahead word FIFO; push while full is dropped, pop while
//            empty is ignored.
// Revision : 1.0  initial release
// ============================================================================
module screen_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/screen_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : screen_frame_sequencer
// Purpose  : Paces CPU frame words (or a fill word) into the screen core.
// Revision : 1.0  initial release
// ============================================================================
module screen_frame_sequencer
    import screen_pkg::*;
#(
    parameter int WORDS_PER_FRAME = c_WORDS_PER_FRAME,
    parameter int GAP             = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                clear_req,
    input  logic [c_WORD_W-1:0] clear_word,
    input  logic                cpu_push,
    input  logic [c_WORD_W-1:0] cpu_data,
    output logic                cpu_full,
    output logic [c_WORD_W-1:0] mat_in,
    output logic                wr_data,
    output logic                init,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow
);

    localparam int c_CNT_W  = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_WORD = c_CNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(FIFO_DEPTH);
    localparam logic [3:0]          c_GAP       = 4'(GAP);

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [3:0]          r_gap_cnt;
    logic [c_CNT_W-1:0]  r_word_cnt;
    logic                r_clear_flag;
    logic [c_WORD_W-1:0] r_clear_word;
    logic [c_WORD_W-1:0] r_mat_last;
    logic                r_overflow;

    logic                w_wr;
    logic                w_pop;
    logic                w_last;
    logic                w_accept_start;
    logic                w_accept_clear;
    logic                w_drop;
    logic [c_WORD_W-1:0] w_wr_word;
    logic [c_WORD_W-1:0] w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [c_FCNT_W-1:0] w_fifo_count;

    screen_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cpu_push),
        .pop   (w_pop),
        .din   (cpu_data),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    // clear_req wins over start when both arrive in the same idle cycle.
    assign w_accept_clear = (r_state == c_ST_IDLE) && clear_req;
    assign w_accept_start = (r_state == c_ST_IDLE) && start && !clear_req;
    assign w_drop         = cpu_push && (w_fifo_count == c_FIFO_FULL);
    assign w_last         = w_wr && (r_word_cnt == c_LAST_WORD);
    assign w_wr_word      = (r_state == c_ST_CLEAR) ? r_clear_word : w_fifo_dout;

    assign cpu_full = w_fifo_full;
    assign overflow = r_overflow;
    assign wr_data  = w_wr;
    assign mat_in   = w_wr ? w_wr_word : r_mat_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept_clear || w_accept_start) w_next_state = c_ST_INIT;
            c_ST_INIT:   w_next_state = r_clear_flag ? c_ST_CLEAR : c_ST_STREAM;
            c_ST_STREAM: if (w_last) w_next_state = c_ST_DONE;
            c_ST_CLEAR:  if (w_last) w_next_state = c_ST_DONE;
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != c_ST_IDLE);
        init       = 1'b0;
        frame_done = 1'b0;
        w_wr       = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            c_ST_INIT:   init = 1'b1;
            c_ST_STREAM: begin
                if ((r_gap_cnt == 4'd0) && !w_fifo_empty) begin
                    w_wr  = 1'b1;
                    w_pop = 1'b1;
                end
            end
            c_ST_CLEAR:  w_wr = (r_gap_cnt == 4'd0);
            c_ST_DONE:   frame_done = 1'b1;
            default:     ;
        endcase
    end

    // Gap counter is zeroed in INIT so the first write always lands right after init.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt    <= 4'd0;
            r_word_cnt   <= '0;
            r_clear_flag <= 1'b0;
            r_clear_word <= '0;
            r_mat_last   <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_state == c_ST_INIT)   r_gap_cnt <= 4'd0;
            else if (w_wr)              r_gap_cnt <= c_GAP;
            else if (r_gap_cnt != 4'd0) r_gap_cnt <= r_gap_cnt - 4'd1;

            if (r_state == c_ST_INIT) r_word_cnt <= '0;
            else if (w_wr)            r_word_cnt <= w_last ? '0 : r_word_cnt + c_CNT_ONE;

            if (w_accept_clear) begin
                r_clear_flag <= 1'b1;
                r_clear_word <= clear_word;
            end else if (w_accept_start) begin
                r_clear_flag <= 1'b0;
            end

            if (w_wr) r_mat_last <= w_wr_word;

            if (w_drop)              r_overflow <= 1'b1;
            else if (w_accept_start) r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_screen_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_screen_frame_sequencer
// Purpose  : Directed bench with an output scoreboard for the frame sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_screen_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        start = 0, clear_req = 0, cpu_push = 0;
    logic [31:0] clear_word = 0, cpu_data = 0;
    logic        cpu_full, wr_data, init, busy, frame_done, overflow;
    logic [31:0] mat_in;

    // Short-frame instance (4 words, gap 2)
    logic        s_start = 0, s_push = 0;
    logic [31:0] s_data = 0;
    logic        s_full, s_wr, s_init, s_busy, s_done, s_ovf;
    logic [31:0] s_mat;

    int          checks = 0, errors = 0;
    int          cyc = 0, wr_total = 0, done_cnt = 0, push_cyc = 0;
    bit          lat_chk = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_mat = 0;

    screen_frame_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .clear_req(clear_req),
        .clear_word(clear_word), .cpu_push(cpu_push), .cpu_data(cpu_data),
        .cpu_full(cpu_full), .mat_in(mat_in), .wr_data(wr_data), .init(init),
        .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    screen_frame_sequencer #(.WORDS_PER_FRAME(4), .GAP(2), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .clear_req(1'b0),
        .clear_word(32'd0), .cpu_push(s_push), .cpu_data(s_data),
        .cpu_full(s_full), .mat_in(s_mat), .wr_data(s_wr), .init(s_init),
        .busy(s_busy), .frame_done(s_done), .overflow(s_ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"},    {31'd0, wr_data},    32'd0);
        check({tag, "_init"},  {31'd0, init},       32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_done"},  {31'd0, frame_done}, 32'd0);
        check({tag, "_ovf"},   {31'd0, overflow},   32'd0);
        check({tag, "_full"},  {31'd0, cpu_full},   32'd0);
        check({tag, "_mat"},   mat_in,              32'd0);
    endtask

    // Scoreboard monitor: every strobe pops one expected word; mat_in holds otherwise.
    always @(negedge clk) begin
        if (rst) begin
            last_mat = 32'd0;
        end else begin
            if (wr_data) begin
                if (exp_q.size() == 0) check("sb_unexpected_wr", {31'd0, wr_data}, 32'd0);
                else                   check("sb_data", mat_in, exp_q.pop_front());
                if (lat_chk) check("push_to_wr_latency", cyc, push_cyc + 1);
                wr_total++;
                last_mat = mat_in;
            end else begin
                check("mat_hold", mat_in, last_mat);
            end
            if (frame_done) done_cnt++;
        end
        if (cpu_push) push_cyc = cyc;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, d0, n, busy_bad, wcount;
        logic exp_wr;

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Short frame: preload 0x11..0x44, start at N
        for (int i = 0; i < 4; i++) begin
            s_push = 1'b1;
            s_data = 32'h11 * (i + 1);
            tick();
        end
        s_push = 1'b0;
        check("s_full_preload", {31'd0, s_full}, 32'd1);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k > 1) tick();
            exp_wr = (k == 2 || k == 5 || k == 8 || k == 11);
            check("s_init", {31'd0, s_init}, {31'd0, k == 1});
            check("s_wr",   {31'd0, s_wr},   {31'd0, exp_wr});
            if (exp_wr) check("s_mat", s_mat, 32'h11 * ((k + 1) / 3));
            check("s_done", {31'd0, s_done}, {31'd0, k == 12});
        end
        check("s_idle_after", {31'd0, s_busy}, 32'd0);

        // Overflow: five pushes, fifth dropped
        for (int i = 0; i < 5; i++) begin
            cpu_push = 1'b1;
            cpu_data = 32'hA0 + i;
            tick();
            if (i == 3) begin
                check("full_after_4", {31'd0, cpu_full}, 32'd1);
                check("ovf_before_5", {31'd0, overflow}, 32'd0);
            end
        end
        cpu_push = 1'b0;
        check("ovf_after_5",  {31'd0, overflow}, 32'd1);
        check("full_after_5", {31'd0, cpu_full}, 32'd1);

        // Clear frame: clear_req and start together, fill word latched
        clear_req  = 1'b1;
        start      = 1'b1;
        clear_word = 32'h00FF00FF;
        repeat (96) exp_q.push_back(32'h00FF00FF);
        base = wr_total;
        tick();
        clear_req  = 1'b0;
        start      = 1'b0;
        clear_word = 32'h12345678;
        check("clr_init", {31'd0, init}, 32'd1);
        n = 0;
        busy_bad = 0;
        while (!frame_done && n < 400) begin
            if (!busy) busy_bad++;
            tick();
            n++;
        end
        check("clr_done_seen", {31'd0, frame_done}, 32'd1);
        check("clr_busy_low_cycles", busy_bad, 0);
        tick();
        check("clr_wr_count", wr_total - base, 96);
        check("clr_sb_drained", exp_q.size(), 0);
        check("clr_fifo_untouched", {31'd0, cpu_full}, 32'd1);

        // Stream: 4 preloaded words, then one push every 10 cycles
        start = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        base = wr_total;
        d0   = done_cnt;
        tick();
        start = 1'b0;
        check("str_init", {31'd0, init}, 32'd1);
        check("ovf_cleared_by_start", {31'd0, overflow}, 32'd0);
        repeat (20) tick();
        check("str_drained_4", wr_total - base, 4);
        check("str_busy_waiting", {31'd0, busy}, 32'd1);
        lat_chk = 1'b1;
        for (int i = 0; i < 92; i++) begin
            cpu_push = 1'b1;
            cpu_data = 32'h1000 + i;
            exp_q.push_back(32'h1000 + i);
            if (i == 30) start = 1'b1;
            tick();
            cpu_push = 1'b0;
            if (i == 30) begin
                start = 1'b0;
                check("mid_start_no_init", {31'd0, init}, 32'd0);
            end
            repeat (9) tick();
        end
        lat_chk = 1'b0;
        check("str_wr_count", wr_total - base, 96);
        check("str_one_done", done_cnt - d0, 1);
        check("str_sb_drained", exp_q.size(), 0);
        check("str_idle", {31'd0, busy}, 32'd0);

        // Reset during a frame, right on the 50th write
        clear_req  = 1'b1;
        clear_word = 32'hDEADBEEF;
        repeat (96) exp_q.push_back(32'hDEADBEEF);
        tick();
        clear_req = 1'b0;
        n = 0;
        wcount = 0;
        while (wcount < 50 && n < 400) begin
            tick();
            n++;
            if (wr_data) wcount++;
        end
        check("rst_reached_50", wcount, 50);
        rst  = 1'b1;
        base = wr_total;
        d0   = done_cnt;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("rst_no_more_wr", wr_total - base, 0);
        check("rst_no_done", done_cnt - d0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fresh_init", {31'd0, init}, 32'd1);
        tick();
        check("fresh_busy", {31'd0, busy}, 32'd1);
        check("fresh_no_wr_empty", {31'd0, wr_data}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/screen_frame_sequencer.md
SCREEN_FRAME_SEQUENCER -- requirements
Module: screen_frame_sequencer

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 96, meaning the number of 32-bit words per 32x32 RGB frame (32*32*3/32).
REQ-002 SHALL have parameter GAP, default 2, meaning the minimum number of idle cycles between consecutive wr_data pulses (range 0..15).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the CPU word buffer depth (power of two).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin streaming a frame from the FIFO.
REQ-007 SHALL have port clear_req, input, 1 bit: one-cycle request to fill a frame with clear_word.
REQ-008 SHALL have port clear_word, input, 32 bits: fill value, sampled on the cycle clear_req is accepted.
REQ-009 SHALL have port cpu_push, input, 1 bit: write strobe for cpu_data into the FIFO.
REQ-010 SHALL have port cpu_data, input, 32 bits: frame word from the bus.
REQ-011 SHALL have port cpu_full, output, 1 bit: high when the FIFO holds FIFO_DEPTH words.
REQ-012 SHALL have port mat_in, output, 32 bits: word presented to the screen core.
REQ-013 SHALL have port wr_data, output, 1 bit: one-cycle strobe qualifying mat_in.
REQ-014 SHALL have port init, output, 1 bit: one-cycle pulse that resets the screen core's write address.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag for a dropped push.

Function
REQ-018 SHALL implement the states IDLE, INIT, STREAM, CLEAR and DONE.
REQ-019 SHALL move IDLE->INIT on start, or IDLE->INIT with the clear flag set on clear_req.
REQ-020 SHALL give clear_req priority over start when both are high in the same IDLE cycle.
REQ-021 SHALL ignore start and clear_req outside IDLE, with no queuing.
REQ-022 SHALL assert init for exactly one cycle while in INIT, then go to CLEAR if the clear flag is set, else STREAM.
REQ-023 SHALL, in STREAM, when the gap counter is zero and the FIFO is not empty, pop one word, drive it on mat_in, pulse wr_data for that cycle, and load the gap counter with GAP.
REQ-024 SHALL, in STREAM, wait indefinitely while the FIFO is empty, with no timeout.
REQ-025 SHALL, in CLEAR, issue identical paced writes of the latched clear_word without touching the FIFO.
REQ-026 SHALL use a word counter 0..WORDS_PER_FRAME-1, incremented per wr_data.
REQ-027 SHALL, on the write where the counter reaches WORDS_PER_FRAME-1, go to DONE, reset the counter to 0, and assert nothing further.
REQ-028 SHALL, in DONE, pulse frame_done for one cycle, then return to IDLE.
REQ-029 SHALL give a first wr_data no earlier than 2 cycles after the start cycle (start at N -> init at N+1 -> wr_data at N+2).
REQ-030 SHALL, with GAP=g, space wr_data pulses exactly g+1 cycles apart when data is available.
REQ-031 SHALL accept cpu_push in any state, including IDLE (preload).
REQ-032 SHALL drop a push while cpu_full is high, even with a simultaneous pop, and set overflow.
REQ-033 SHALL, on a push and pop in the same cycle when not full, leave the occupancy unchanged.
REQ-034 SHALL clear overflow only on accepted start, or on rst.
REQ-035 SHALL hold mat_in at its last value between strobes.
REQ-036 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with a separate occupancy count to distinguish full from empty.

Reset
REQ-037 SHALL, on rst, return to IDLE and clear the FIFO, word counter and gap counter.
REQ-038 SHALL reset mat_in=0, wr_data=0, init=0, busy=0, frame_done=0, overflow=0 and cpu_full=0.
REQ-039 SHALL let rst mid-frame abort immediately, with no frame_done and no further writes.

Structure
REQ-040 SHALL place the state encoding and the WORDS_PER_FRAME default (96) in the shared screen package used by the screen peripheral.
REQ-041 SHALL implement the FIFO as sub-module screen_word_fifo (push, pop, din, dout, full, empty, count).

Verification
REQ-042 SHALL cover: preload 4 words 0x11..0x44, then start, with WORDS_PER_FRAME=4 and GAP=2 -> init at N+1; wr_data at N+2, N+5, N+8, N+11 carrying 0x11, 0x22, 0x33, 0x44; frame_done at N+12.
REQ-043 SHALL cover: clear_req with clear_word=0x00FF00FF and start in the same cycle -> 96 writes of 0x00FF00FF, FIFO contents untouched, busy high throughout.
REQ-044 SHALL cover: five pushes with no pops -> cpu_full after the 4th push, 5th push dropped, overflow=1; next start clears overflow.
REQ-045 SHALL cover: start with an empty FIFO, then one push every 10 cycles -> each wr_data follows its push by 1 cycle, and the frame ends after the 96th word.
REQ-046 SHALL cover: rst asserted after the 50th write -> no further wr_data, no frame_done, all outputs 0 the next cycle; a fresh start then gives a new init pulse.
REQ-047 SHALL cover: start pulsed during STREAM -> ignored, with no extra init and the counter unaffected.
